// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-read register file with pending-write scoreboard and sequenced clear
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   write      write enable; wR address, dataIn data
//   opA/opB    read addresses; operand_a/operand_b combinational read data
//   reserve    mark entry rsvAddr as pending
//   a_pending  pending bit of entry opA, b_pending of entry opB
//   clear_req  start walking clear of every entry
//   clear_busy clear engine active
module reg_file_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] wR,
    input  logic [DATA_W-1:0] dataIn,
    input  logic [ADDR_W-1:0] opA,
    input  logic [ADDR_W-1:0] opB,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] rsvAddr,
    output logic              a_pending,
    output logic              b_pending,
    input  logic              clear_req,
    output logic              clear_busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    pending;
    logic                idle, we, rs, zr_a, zr_b, byp_a, byp_b;
    always_comb begin
        idle      = state == IDLE;
        // entry 0 is hardwired when ZERO_REG is set: no write, no reserve, no bypass
        we        = write && idle && !(ZERO_REG != 0 && wR == '0);
        rs        = reserve && idle && !(ZERO_REG != 0 && rsvAddr == '0);
        zr_a      = ZERO_REG != 0 && opA == '0;
        zr_b      = ZERO_REG != 0 && opB == '0;
        byp_a     = write && idle && wR == opA && !zr_a;
        byp_b     = write && idle && wR == opB && !zr_b;
        operand_a = zr_a ? '0 : byp_a ? dataIn : mem[opA];
        operand_b = zr_b ? '0 : byp_b ? dataIn : mem[opB];
        a_pending = byp_a ? 1'b0 : pending[opA];
        b_pending = byp_b ? 1'b0 : pending[opB];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            pending    <= '0;
            state      <= IDLE;
            ptr        <= '0;
            clear_busy <= 1'b0;
        end else if (state == IDLE) begin
            if (we) begin
                mem[wR]     <= dataIn;
                pending[wR] <= 1'b0;
            end
            // reserve after write so a same-entry write+reserve leaves it pending
            if (rs) pending[rsvAddr] <= 1'b1;
            if (clear_req) begin
                state      <= CLEAR;
                ptr        <= '0;
                clear_busy <= 1'b1;
            end
        end else begin
            mem[ptr]     <= '0;
            pending[ptr] <= 1'b0;
            ptr          <= ptr + 1'b1;
            if (ptr == ADDR_W'(DEPTH - 1)) begin
                state      <= IDLE;
                clear_busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed scoreboard bench for reg_file_sb (default and ZERO_REG=1 instances)
module tb_reg_file_sb;
    logic       clk = 1'b0, reset = 1'b0;
    logic       write = 1'b0, reserve = 1'b0, clear_req = 1'b0;
    logic [2:0] wR = '0, opA = '0, opB = '0, rsvAddr = '0;
    logic [7:0] dataIn = '0;
    logic [7:0] operand_a, operand_b, z_a, z_b;
    logic       a_pending, b_pending, clear_busy, z_pa, z_pb, z_busy;
    int total = 0, bad = 0;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] exp;
    } item_t;
    item_t q[$];

    localparam int OA = 0, OB = 1, PA = 2, PB = 3, BUSY = 4, ZOA = 5, ZPA = 6;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk(clk), .reset(reset), .write(write), .wR(wR), .dataIn(dataIn),
        .opA(opA), .opB(opB), .operand_a(operand_a), .operand_b(operand_b),
        .reserve(reserve), .rsvAddr(rsvAddr), .a_pending(a_pending), .b_pending(b_pending),
        .clear_req(clear_req), .clear_busy(clear_busy)
    );

    reg_file_sb #(.ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .write(write), .wR(wR), .dataIn(dataIn),
        .opA(opA), .opB(opB), .operand_a(z_a), .operand_b(z_b),
        .reserve(reserve), .rsvAddr(rsvAddr), .a_pending(z_pa), .b_pending(z_pb),
        .clear_req(clear_req), .clear_busy(z_busy)
    );

    function automatic logic [7:0] obs(input int s);
        case (s)
            OA:      return operand_a;
            OB:      return operand_b;
            PA:      return {7'd0, a_pending};
            PB:      return {7'd0, b_pending};
            BUSY:    return {7'd0, clear_busy};
            ZOA:     return z_a;
            default: return {7'd0, z_pa};
        endcase
    endfunction

    task automatic push(input string t, input int s, input logic [7:0] e);
        item_t it;
        it.tag = t;
        it.sel = s;
        it.exp = e;
        q.push_back(it);
    endtask

    task automatic drain();
        item_t      it;
        logic [7:0] o;
        #1;
        while (q.size() > 0) begin
            it = q.pop_front();
            o  = obs(it.sel);
            total++;
            assert (o === it.exp) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", it.tag, o, it.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset state
        #2;
        for (int i = 0; i < 7; i++) begin
            opA = 3'(i);
            opB = 3'(i + 1);
            push($sformatf("rst_a%0d", i), OA, 8'h00);
            push($sformatf("rst_b%0d", i + 1), OB, 8'h00);
            push($sformatf("rst_pa%0d", i), PA, 8'h00);
            push($sformatf("rst_pb%0d", i + 1), PB, 8'h00);
            push("rst_busy", BUSY, 8'h00);
            drain();
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        // 2: write-through bypass
        write = 1'b1; wR = 3'd3; dataIn = 8'h0A; opA = 3'd3; opB = 3'd3;
        push("byp_a", OA, 8'h0A);
        push("byp_b", OB, 8'h0A);
        drain();
        tick();
        write = 1'b0;
        push("wr_a", OA, 8'h0A);
        push("wr_b", OB, 8'h0A);
        drain();
        // 3: reserve / pending
        reserve = 1'b1; rsvAddr = 3'd5; opA = 3'd5;
        push("rsv_pre", PA, 8'h00);
        drain();
        tick();
        reserve = 1'b0;
        push("rsv_pa", PA, 8'h01);
        drain();
        write = 1'b1; wR = 3'd5; dataIn = 8'h55;
        push("rsv_byp_pa", PA, 8'h00);
        push("rsv_byp_a", OA, 8'h55);
        drain();
        tick();
        write = 1'b0;
        push("rsv_done_pa", PA, 8'h00);
        push("rsv_done_a", OA, 8'h55);
        drain();
        write = 1'b1; wR = 3'd6; dataIn = 8'h66; reserve = 1'b1; rsvAddr = 3'd6;
        tick();
        write = 1'b0; reserve = 1'b0; opB = 3'd6;
        push("wr_rsv_b", OB, 8'h66);
        push("wr_rsv_pb", PB, 8'h01);
        drain();
        // 4: fill, then sequenced clear
        for (int i = 0; i < 8; i++) begin
            write = 1'b1; wR = 3'(i); dataIn = 8'(8'hF0 + i);
            tick();
        end
        write = 1'b0; opA = 3'd7; opB = 3'd4;
        push("fill_a7", OA, 8'hF7);
        push("fill_b4", OB, 8'hF4);
        drain();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            opA = 3'd7; opB = 3'd0;
            if (c == 0) begin
                write = 1'b1; wR = 3'd7; dataIn = 8'hAA; clear_req = 1'b1;
                push("clr_nobyp_a7", OA, 8'hF7);
                push("clr_b0_old", OB, 8'hF0);
            end
            if (c == 3) begin
                push("clr_mid_a7", OA, 8'hF7);
                push("clr_mid_b0", OB, 8'h00);
            end
            push($sformatf("clr_busy%0d", c), BUSY, 8'h01);
            drain();
            tick();
            write = 1'b0; clear_req = 1'b0;
        end
        push("clr_end_busy", BUSY, 8'h00);
        drain();
        for (int i = 0; i < 8; i += 2) begin
            opA = 3'(i); opB = 3'(i + 1);
            push($sformatf("clr_a%0d", i), OA, 8'h00);
            push($sformatf("clr_b%0d", i + 1), OB, 8'h00);
            drain();
        end
        // 5: reset in the middle of a clear
        write = 1'b1; wR = 3'd2; dataIn = 8'h22;
        tick();
        wR = 3'd7; dataIn = 8'h77; reserve = 1'b1; rsvAddr = 3'd7;
        tick();
        write = 1'b0; reserve = 1'b0; clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        tick();
        tick();
        opA = 3'd7; opB = 3'd2;
        push("mid_busy", BUSY, 8'h01);
        push("mid_a7", OA, 8'h77);
        push("mid_pa7", PA, 8'h01);
        drain();
        reset = 1'b0;
        push("arst_busy", BUSY, 8'h00);
        push("arst_a7", OA, 8'h00);
        push("arst_b2", OB, 8'h00);
        push("arst_pa7", PA, 8'h00);
        drain();
        #1;
        reset = 1'b1;
        tick();
        push("post_busy", BUSY, 8'h00);
        push("post_a7", OA, 8'h00);
        drain();
        // 6: hardwired zero entry vs normal entry 0
        write = 1'b1; wR = 3'd0; dataIn = 8'hFF; reserve = 1'b1; rsvAddr = 3'd0;
        opA = 3'd0; opB = 3'd0;
        push("z_nobyp_a", ZOA, 8'h00);
        push("n_byp_a", OA, 8'hFF);
        drain();
        tick();
        write = 1'b0; reserve = 1'b0;
        push("z_a0", ZOA, 8'h00);
        push("z_pa0", ZPA, 8'h00);
        push("n_a0", OA, 8'hFF);
        push("n_pa0", PA, 8'h01);
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
